// File: rtl/hub75_scan.sv
// HUB75 64x32 scan-out engine: fetches row-pair pixels from the frame RAM, shifts one
// bitplane at a time onto the panel, latches it and shows it for a binary-weighted time.
module hub75_scan #(
    parameter int unsigned BITS_PER_PIXEL = 32,
    parameter int unsigned BASE_TICKS     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [9:0]                read_addr,
    output logic                      read_en,
    input  logic [BITS_PER_PIXEL-1:0] read_data_top,
    input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
    output logic                      frame_done,
    output logic                      hub75_clk,
    output logic                      hub75_lat,
    output logic                      hub75_oe,
    output logic [3:0]                hub75_row,
    output logic [2:0]                hub75_rgb_top,
    output logic [2:0]                hub75_rgb_bottom
);

    typedef enum logic [1:0] {StShift, StLatch, StDisplay} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] tick_q, tick_d;
    logic [3:0] row_q, row_d;
    logic [2:0] plane_q, plane_d;

    logic [9:0] addr_q, addr_d;
    logic       ren_q, ren_d;
    logic       fd_q, fd_d;
    logic       hclk_q, hclk_d;
    logic       lat_q, lat_d;
    logic       oe_q, oe_d;
    logic [3:0] hrow_q, hrow_d;
    logic [2:0] rgb_top_q, rgb_top_d;
    logic [2:0] rgb_bot_q, rgb_bot_d;

    logic [9:0] disp_len;
    logic       unused_alpha;

    assign disp_len     = 10'(BASE_TICKS) << plane_q;
    assign unused_alpha = ^{read_data_top[BITS_PER_PIXEL-1:24],
                            read_data_bottom[BITS_PER_PIXEL-1:24]};

    function automatic logic [2:0] plane_bits(input logic [23:0] px, input logic [2:0] p);
        logic [7:0] r, g, b;
        r = px[23:16];
        g = px[15:8];
        b = px[7:0];
        return {r[p], g[p], b[p]};
    endfunction

    // The output registers run one cycle behind the state: cnt_q == k computes what the
    // panel sees in SHIFT cycle k, so the cycle right after reset still shows reset values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tick_d    = tick_q;
        row_d     = row_q;
        plane_d   = plane_q;
        addr_d    = addr_q;
        ren_d     = 1'b0;
        fd_d      = 1'b0;
        hclk_d    = 1'b0;
        lat_d     = 1'b0;
        oe_d      = 1'b1;
        hrow_d    = hrow_q;
        rgb_top_d = rgb_top_q;
        rgb_bot_d = rgb_bot_q;

        unique case (state_q)
            StShift: begin
                cnt_d = cnt_q + 8'd1;
                if (!cnt_q[0] && cnt_q <= 8'd126) begin
                    ren_d  = 1'b1;
                    addr_d = {row_q, cnt_q[6:1]};
                end
                // Data for the fetch two cycles back is on the RAM outputs now.
                if (!cnt_q[0] && cnt_q >= 8'd2) begin
                    rgb_top_d = plane_bits(read_data_top[23:0], plane_q);
                    rgb_bot_d = plane_bits(read_data_bottom[23:0], plane_q);
                end
                if (cnt_q[0] && cnt_q >= 8'd3) begin
                    hclk_d = 1'b1;
                end
                if (cnt_q == 8'd129) begin
                    cnt_d   = 8'd0;
                    state_d = StLatch;
                end
            end
            StLatch: begin
                lat_d   = 1'b1;
                hrow_d  = row_q;
                tick_d  = 10'd0;
                state_d = StDisplay;
            end
            StDisplay: begin
                oe_d   = 1'b0;
                tick_d = tick_q + 10'd1;
                if (tick_q == disp_len - 10'd1) begin
                    tick_d  = 10'd0;
                    state_d = StShift;
                    fd_d    = (row_q == 4'd15) && (plane_q == 3'd7);
                    plane_d = plane_q + 3'd1;
                    if (plane_q == 3'd7) begin
                        row_d = row_q + 4'd1;
                    end
                end
            end
            default: state_d = StShift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StShift;
            cnt_q     <= 8'd0;
            tick_q    <= 10'd0;
            row_q     <= 4'd0;
            plane_q   <= 3'd0;
            addr_q    <= 10'd0;
            ren_q     <= 1'b0;
            fd_q      <= 1'b0;
            hclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            oe_q      <= 1'b1;
            hrow_q    <= 4'd0;
            rgb_top_q <= 3'd0;
            rgb_bot_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            row_q     <= row_d;
            plane_q   <= plane_d;
            addr_q    <= addr_d;
            ren_q     <= ren_d;
            fd_q      <= fd_d;
            hclk_q    <= hclk_d;
            lat_q     <= lat_d;
            oe_q      <= oe_d;
            hrow_q    <= hrow_d;
            rgb_top_q <= rgb_top_d;
            rgb_bot_q <= rgb_bot_d;
        end
    end

    assign read_addr        = addr_q;
    assign read_en          = ren_q;
    assign frame_done       = fd_q;
    assign hub75_clk        = hclk_q;
    assign hub75_lat        = lat_q;
    assign hub75_oe         = oe_q;
    assign hub75_row        = hrow_q;
    assign hub75_rgb_top    = rgb_top_q;
    assign hub75_rgb_bottom = rgb_bot_q;

endmodule

// File: tb/tb_hub75_scan.sv
// Bench for hub75_scan: 1-cycle-latency RAM model plus a cycle-position reference model
// derived from the scan timing rules; every cycle is compared against it.
module tb_hub75_scan;

    localparam int BASE   = 4;
    localparam int ROW_P  = 8 * 131 + BASE * 255;
    localparam int FRAME  = 16 * ROW_P;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  read_addr;
    logic        read_en;
    logic [31:0] read_data_top = 32'd0;
    logic [31:0] read_data_bottom = 32'd0;
    logic        frame_done, hub75_clk, hub75_lat, hub75_oe;
    logic [3:0]  hub75_row;
    logic [2:0]  hub75_rgb_top, hub75_rgb_bottom;

    logic [31:0] top_mem [1024];
    logic [31:0] bot_mem [1024];

    int n_assert = 0;
    int n_fail   = 0;
    int n        = -1;
    logic       cur_clk = 1'b0, pclk = 1'b0;
    logic [5:0] cur_rgb = 6'd0, prgb = 6'd0;

    hub75_scan #(.BITS_PER_PIXEL(32), .BASE_TICKS(BASE)) dut (
        .clk              (clk),
        .reset            (reset),
        .read_addr        (read_addr),
        .read_en          (read_en),
        .read_data_top    (read_data_top),
        .read_data_bottom (read_data_bottom),
        .frame_done       (frame_done),
        .hub75_clk        (hub75_clk),
        .hub75_lat        (hub75_lat),
        .hub75_oe         (hub75_oe),
        .hub75_row        (hub75_row),
        .hub75_rgb_top    (hub75_rgb_top),
        .hub75_rgb_bottom (hub75_rgb_bottom)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read_en) begin
            read_data_top    <= top_mem[read_addr];
            read_data_bottom <= bot_mem[read_addr];
        end
    end

    function automatic logic [2:0] bits(input logic [31:0] px, input int pl);
        return {px[16 + pl], px[8 + pl], px[pl]};
    endfunction

    function automatic int plane_start(input int pl);
        int s;
        s = 0;
        for (int b = 0; b < pl; b++) s += 131 + (BASE << b);
        return s;
    endfunction

    // Expected {read_en, read_addr, frame_done, clk, lat, oe, row, rgb_top, rgb_bottom}
    // for scan cycle n counted from the first SHIFT cycle after reset.
    function automatic logic [24:0] model(input int cyc);
        int fr, p, row, o, pl, t, g, prow, ppl, col;
        logic ren, fd, hc, lat, oe;
        logic [9:0] addr;
        logic [3:0] hrow;
        logic [2:0] rt, rb;
        fr  = cyc / FRAME;
        p   = cyc % FRAME;
        row = p / ROW_P;
        o   = p % ROW_P;
        pl  = 0;
        while (o >= 131 + (BASE << pl)) begin
            o -= 131 + (BASE << pl);
            pl++;
        end
        t    = BASE << pl;
        g    = fr * 128 + row * 8 + pl;
        ren  = (o <= 126) && (o % 2 == 0);
        addr = 10'(row * 64 + ((o <= 126) ? o / 2 : 63));
        hc   = (o >= 3) && (o <= 129) && (o % 2 == 1);
        lat  = (o == 130);
        oe   = !(o > 130);
        fd   = (row == 15) && (pl == 7) && (o == 130 + t);
        prow = (pl > 0) ? row : (row + 15) % 16;
        ppl  = (pl > 0) ? pl - 1 : 7;
        if (o >= 130)    hrow = 4'(row);
        else if (g == 0) hrow = 4'd0;
        else             hrow = 4'(prow);
        if (o >= 2) begin
            col = (o >= 130) ? 63 : (o - 2) / 2;
            rt  = bits(top_mem[row * 64 + col], pl);
            rb  = bits(bot_mem[row * 64 + col], pl);
        end else if (g == 0) begin
            rt = 3'd0;
            rb = 3'd0;
        end else begin
            rt = bits(top_mem[prow * 64 + 63], ppl);
            rb = bits(bot_mem[prow * 64 + 63], ppl);
        end
        return {ren, addr, fd, hc, lat, oe, hrow, rt, rb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [24:0] obs, exp;
        obs = {read_en, read_addr, frame_done, hub75_clk, hub75_lat, hub75_oe, hub75_row,
               hub75_rgb_top, hub75_rgb_bottom};
        exp = (n < 0) ? {1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 3'd0} : model(n);
        chk($sformatf("cycle n=%0d", n), 32'(obs), 32'(exp));
        chk("lat_with_oe_low", 32'(hub75_lat & ~hub75_oe), 32'd0);
        if (hub75_clk) chk($sformatf("rgb_hold n=%0d", n), 32'(cur_rgb), 32'(prgb));
    endtask

    task automatic step();
        logic r;
        r    = reset;
        pclk = cur_clk;
        prgb = cur_rgb;
        @(posedge clk);
        n = r ? -1 : n + 1;
        @(negedge clk);
        cur_clk = hub75_clk;
        cur_rgb = {hub75_rgb_top, hub75_rgb_bottom};
        check_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int fd_q[$];
        int edge_q[$];
        int first_lat, oe_low, edges, bad_edges, target, sparse_lat_row;

        // Random pixels, two free-running frames.
        for (int i = 0; i < 1024; i++) begin
            top_mem[i] = $urandom;
            bot_mem[i] = $urandom;
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        first_lat = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (frame_done) fd_q.push_back(n);
            if (hub75_lat && first_lat < 0) first_lat = n;
        end
        chk("first_latch_cycle", 32'(first_lat), 32'd130);
        chk("frame_done_count", 32'(fd_q.size()), 32'd2);
        if (fd_q.size() == 2) begin
            chk("frame_done_0", 32'(fd_q[0]), 32'(FRAME - 1));
            chk("frame_done_1", 32'(fd_q[1]), 32'(2 * FRAME - 1));
        end

        // Uniform 0x00FF00FF: every edge shows 101, one row keeps oe low 1020 cycles.
        for (int i = 0; i < 1024; i++) begin
            top_mem[i] = 32'h00FF00FF;
            bot_mem[i] = 32'h00FF00FF;
        end
        do_reset();
        oe_low    = 0;
        edges     = 0;
        bad_edges = 0;
        for (int i = 0; i < ROW_P; i++) begin
            step();
            if (!hub75_oe) oe_low++;
            if (hub75_clk && !pclk) begin
                edges++;
                if (cur_rgb != 6'b101101) bad_edges++;
            end
        end
        chk("row_oe_low_cycles", 32'(oe_low), 32'd1020);
        chk("row_clock_edges", 32'(edges), 32'd512);
        chk("uniform_bad_edges", 32'(bad_edges), 32'd0);

        // Single lit pixel pair at (5,3)/(5,19); then a reset mid-DISPLAY of row 7 plane 4.
        for (int i = 0; i < 1024; i++) begin
            top_mem[i] = 32'd0;
            bot_mem[i] = 32'd0;
        end
        top_mem[3 * 64 + 5] = 32'h00000080;
        bot_mem[3 * 64 + 5] = 32'h00800000;
        do_reset();
        sparse_lat_row = -1;
        target = 7 * ROW_P + plane_start(4) + 133;
        while (n < target) begin
            step();
            if (hub75_clk && !pclk && cur_rgb != 6'd0) edge_q.push_back(n);
            if (n == 3 * ROW_P + plane_start(7) + 130 && hub75_lat) sparse_lat_row = hub75_row;
        end
        chk("sparse_edge_count", 32'(edge_q.size()), 32'd1);
        if (edge_q.size() >= 1) begin
            chk("sparse_edge_cycle", 32'(edge_q[0]), 32'(3 * ROW_P + plane_start(7) + 13));
        end
        chk("sparse_latch_row", 32'(sparse_lat_row), 32'd3);

        reset = 1'b1;
        step();
        chk("midreset_oe", 32'(hub75_oe), 32'd1);
        chk("midreset_row", 32'(hub75_row), 32'd0);
        chk("midreset_read_en", 32'(read_en), 32'd0);
        reset = 1'b0;
        step();
        chk("restart_read_en", 32'(read_en), 32'd1);
        chk("restart_read_addr", 32'(read_addr), 32'd0);
        for (int i = 0; i < 300; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hub75_scan.md
# hub75_scan

Scan-out engine for the 64x32 HUB75 panel. Sits directly downstream of `sync_pdp_ram` and drives that RAM's read port. For each row pair it fetches the top and bottom pixels, then serialises one bitplane at a time onto the panel shift registers. It then latches the row and enables the LEDs for a binary-weighted time, giving 8-bit-per-channel BCM brightness. It also tells the upstream writer when a frame is complete, so the writer can flip buffers.

## Interface
Parameters:
- BITS_PER_PIXEL, 32: RAM word width. Pixel format: R=[23:16], G=[15:8], B=[7:0]; [31:24] ignored.
- BASE_TICKS, 4: display cycles for bitplane 0. Plane b displays for BASE_TICKS<<b cycles.

Ports:
- clk, input, 1: single clock. The RAM read port is clocked from this clock.
- reset, input, 1: synchronous, active-high.
- read_addr, output, 10: RAM read address {row[3:0], col[5:0]}.
- read_en, output, 1: RAM read enable.
- read_data_top, input, BITS_PER_PIXEL: pixel (col, row). Valid the cycle after read_en.
- read_data_bottom, input, BITS_PER_PIXEL: pixel (col, row+16). Same timing as read_data_top.
- frame_done, output, 1: one-cycle pulse at end of frame.
- hub75_clk, output, 1: panel shift clock.
- hub75_lat, output, 1: panel latch, active-high.
- hub75_oe, output, 1: panel output enable, active-low.
- hub75_row, output, 4: panel row select A-D.
- hub75_rgb_top, output, 3: {R,G,B} bit of the current plane for the top half.
- hub75_rgb_bottom, output, 3: {R,G,B} bit of the current plane for the bottom half.

## Operation
- Counters:
  - row: 0..15
  - plane: 0..7
  - col: 0..63
  - display tick counter: 10 bits, sufficient for 4<<7=512
- FSM states: SHIFT, LATCH, DISPLAY.
- SHIFT: shifts 64 columns of the current (row, plane).
  - hub75_oe=1 for the whole state (panel blanked).
  - Per column c: issue read_addr={row,c} with read_en=1.
  - On the following cycle, register the colour bits into hub75_rgb_top/bottom:
    - R bit = data[16+plane]
    - G bit = data[8+plane]
    - B bit = data[plane]
  - Then pulse hub75_clk.
- LATCH: one cycle.
  - hub75_lat=1, hub75_oe=1.
  - hub75_row updates to the current row in this cycle.
- DISPLAY: hub75_oe=0 for exactly BASE_TICKS<<plane cycles.
- Advance after DISPLAY:
  - plane<7: plane+1, same row, back to SHIFT.
  - plane=7: plane=0, row+1 (wraps 15->0), back to SHIFT.
- frame_done=1 during the last DISPLAY cycle of row 15, plane 7. Upstream toggles buffer_toggle on that edge, so the next fetch reads the new buffer.
- read_en=0 and read_addr holds its last value outside the fetch cycles.
- hub75_rgb_* hold their last value after the final column of a plane.

## Timing
- Reset values:
  - read_addr=0, read_en=0
  - hub75_clk=0, hub75_lat=0, hub75_oe=1
  - hub75_row=0, hub75_rgb_top=0, hub75_rgb_bottom=0
  - frame_done=0
  - FSM=SHIFT, row=0, plane=0, col=0
- The first cycle after reset deasserts is SHIFT cycle 0.
- SHIFT timing, counting from cycle 0 of SHIFT, for column c:
  - Cycle 2c: read_en=1, read_addr={row,c}.
  - Cycle 2c+1: RAM data valid; rgb registered at the end of this cycle.
  - Cycle 2c+2: rgb valid, hub75_clk=0.
  - Cycle 2c+3: rgb stable, hub75_clk=1. The panel samples on the rising edge at the start of cycle 2c+3.
  - Fetches overlap the previous column's clock phase.
  - SHIFT lasts exactly 130 cycles (cycles 0..129). hub75_clk=1 on cycle 129 and is 0 in the LATCH cycle.
- LATCH: 1 cycle. DISPLAY: BASE_TICKS<<plane cycles.
- Plane period = 131 + (BASE_TICKS<<plane) cycles.
- Row period, default parameters = 8*131 + 4*255 = 2068 cycles.
- Frame period = 16*2068 = 33088 cycles.
- frame_done period equals the frame period; it is never asserted twice in succession.
- Reset mid-operation (any state): the next cycle shows reset values and the scan restarts at row 0, plane 0, col 0. No partial latch is issued.
- hub75_lat and hub75_oe=0 are never asserted in the same cycle.
- hub75_oe is 1 in every SHIFT and LATCH cycle.

## Test plan
- Reset then run with RAM model (1-cycle latency):
  - read_addr steps 0,1,..,63 on even SHIFT cycles 0..126.
  - First hub75_lat at cycle 130.
  - hub75_oe low for cycles 131..134.
  - Second SHIFT starts at cycle 135.
- All pixels 0x00FF00FF:
  - Every plane gives rgb_top=rgb_bottom=3'b101 at each hub75_clk rising edge.
  - Per-row total oe-low count = 1020 cycles.
- Pixel (col 5, row 3)=0x00000080, (col 5, row 19)=0x00800000, all others 0:
  - Only row 3, plane 7, 6th clock edge shows rgb_top=3'b001 and rgb_bottom=3'b100.
  - hub75_row=3 at that plane's latch.
- Free run 2 frames:
  - frame_done pulses exactly at cycles 33087 and 66175.
  - hub75_row sequence 0..15 wraps to 0.
- Assert reset for 1 cycle during DISPLAY of row 7, plane 4:
  - Next cycle: oe=1, row=0, read_en=0.
  - The cycle after: read_en=1 with read_addr=0.
- Every cycle, check:
  - never (lat=1 and oe=0)
  - hub75_rgb_top/bottom unchanged across every cycle where hub75_clk=1
